// File: rtl/lc3b_pipe_pkg.sv
// Shared definitions for the LC-3b pipeline: PC-mux encodings, fetch FSM
// state encodings and the default reset PC.
package lc3b_pipe_pkg;

  // MEM-stage PC source select; the fourth code is reserved and behaves like NPC.
  localparam logic [1:0] PCMUX_NPC    = 2'd0;
  localparam logic [1:0] PCMUX_TARGET = 2'd1;
  localparam logic [1:0] PCMUX_TRAP   = 2'd2;

  // Fetch FSM states. The enum names the states; the localparams carry the
  // same encodings for code that keeps the state in a plain logic vector.
  typedef enum logic [0:0] {
    FETCH   = 1'b0,
    BR_WAIT = 1'b1
  } fetch_state_e;

  localparam logic [0:0] ST_FETCH   = 1'b0;
  localparam logic [0:0] ST_BR_WAIT = 1'b1;

  // PC loaded on reset; must be even.
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h3000;

  // Force a redirect address onto a word boundary.
  function automatic logic [15:0] word_align(input logic [15:0] addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter with enable and asynchronous active-low clear that
// sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] count_reg;
  logic [15:0] count_next;

  // Advance only while enabled and not already saturated.
  always_comb begin
    count_next = count_reg;
    if (en && (count_reg != 16'hFFFF)) begin
      count_next = 16'(count_reg + 16'd1);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 16'h0000;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: owns the PC and the DE pipeline latch, issues icache
// reads, stops fetching while a control instruction is in flight, and takes
// the MEM-stage redirect. Also counts instructions and bubbles sent to DE.
module fetch_stage
  import lc3b_pipe_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] icache_addr,
  output logic        icache_rd,
  input  logic        icache_r,
  input  logic [15:0] icache_data,
  input  logic        v_de_br_stall,
  input  logic        v_agex_br_stall,
  input  logic        v_mem_br_stall,
  input  logic        dep_stall,
  input  logic        mem_stall,
  input  logic [1:0]  mem_pcmux,
  input  logic [15:0] target_pc,
  input  logic [15:0] trap_pc,
  output logic [15:0] de_npc,
  output logic [15:0] de_ir,
  output logic        de_v,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_bubbles
);

  logic [15:0] pc_reg;
  logic [15:0] pc_next;
  logic [0:0]  state_reg;
  logic [0:0]  state_next;
  logic [15:0] de_npc_reg;
  logic [15:0] de_ir_reg;
  logic        de_v_reg;

  logic        br_stall;
  logic        ld_de;
  logic        resolve;
  logic        in_fetch;
  logic        fetch_go;
  logic        de_v_next;
  logic [15:0] pc_plus2;
  logic [15:0] pc_sel;

  // A redirect is only taken once MEM is free to move; a stalled MEM keeps
  // the branch pending and the FSM in BR_WAIT.
  assign br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
  assign ld_de    = ~dep_stall & ~mem_stall;
  assign resolve  = v_mem_br_stall & ~mem_stall;
  assign in_fetch = (state_reg == ST_FETCH);
  assign pc_plus2 = 16'(pc_reg + 16'd2);
  assign fetch_go = in_fetch & icache_r & ld_de & ~br_stall;

  // A resolving redirect beats a same-cycle icache hit, so the word is dropped.
  assign de_v_next = in_fetch & icache_r & ~br_stall & ~resolve;

  // Redirect source; the reserved code falls back to the current PC.
  always_comb begin
    pc_sel = pc_reg;
    case (mem_pcmux)
      PCMUX_TARGET: pc_sel = target_pc;
      PCMUX_TRAP:   pc_sel = trap_pc;
      default:      pc_sel = pc_reg;
    endcase
  end

  // Next PC: redirect first, then sequential advance on a consumed fetch.
  always_comb begin
    pc_next = pc_reg;
    if (resolve) begin
      pc_next = word_align(pc_sel);
    end else if (fetch_go) begin
      pc_next = pc_plus2;
    end
  end

  // FSM: park in BR_WAIT while a control instruction is in flight.
  always_comb begin
    state_next = state_reg;
    if (resolve) begin
      state_next = ST_FETCH;
    end else if (in_fetch && br_stall) begin
      state_next = ST_BR_WAIT;
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      state_reg <= ST_FETCH;
    end else begin
      pc_reg    <= pc_next;
      state_reg <= state_next;
    end
  end

  // DE latch: loads every unstalled cycle, either an instruction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_npc_reg <= 16'h0000;
      de_ir_reg  <= 16'h0000;
      de_v_reg   <= 1'b0;
    end else if (ld_de) begin
      de_npc_reg <= pc_plus2;
      de_ir_reg  <= icache_data;
      de_v_reg   <= de_v_next;
    end
  end

  // Performance counters: index 0 counts instructions, index 1 bubbles.
  logic [1:0]  cnt_en;
  logic [15:0] cnt_val [2];

  assign cnt_en[0] = ld_de & de_v_next;
  assign cnt_en[1] = ld_de & ~de_v_next;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      sat_counter16 u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign icache_addr  = pc_reg;
  assign icache_rd    = in_fetch;
  assign de_npc       = de_npc_reg;
  assign de_ir        = de_ir_reg;
  assign de_v         = de_v_reg;
  assign perf_fetched = cnt_val[0];
  assign perf_bubbles = cnt_val[1];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The icache model returns addr ^ 16'h5A5A so
// every expected instruction word can be written down from its address.
module tb_fetch_stage;

  localparam logic [15:0] K = 16'h5A5A;

  logic        clk;
  logic        rst_n;
  logic [15:0] icache_addr;
  logic        icache_rd;
  logic        icache_r;
  logic [15:0] icache_data;
  logic        v_de_br_stall;
  logic        v_agex_br_stall;
  logic        v_mem_br_stall;
  logic        dep_stall;
  logic        mem_stall;
  logic [1:0]  mem_pcmux;
  logic [15:0] target_pc;
  logic [15:0] trap_pc;
  logic [15:0] de_npc;
  logic [15:0] de_ir;
  logic        de_v;
  logic [15:0] perf_fetched;
  logic [15:0] perf_bubbles;

  int n_pass  = 0;
  int n_total = 0;

  fetch_stage #(.RESET_PC(16'h3000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .icache_addr     (icache_addr),
    .icache_rd       (icache_rd),
    .icache_r        (icache_r),
    .icache_data     (icache_data),
    .v_de_br_stall   (v_de_br_stall),
    .v_agex_br_stall (v_agex_br_stall),
    .v_mem_br_stall  (v_mem_br_stall),
    .dep_stall       (dep_stall),
    .mem_stall       (mem_stall),
    .mem_pcmux       (mem_pcmux),
    .target_pc       (target_pc),
    .trap_pc         (trap_pc),
    .de_npc          (de_npc),
    .de_ir           (de_ir),
    .de_v            (de_v),
    .perf_fetched    (perf_fetched),
    .perf_bubbles    (perf_bubbles)
  );

  assign icache_data = icache_addr ^ K;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    $display("check %-14s observed %h required %h", tag, obs, exp);
  endtask

  // Full DE/PC/counter snapshot.
  task automatic chk_all(input string tag, input logic [15:0] pc, input logic v,
                         input logic [15:0] npc, input logic [15:0] ir,
                         input logic [15:0] nf, input logic [15:0] nb);
    chk({tag, ".pc"}, icache_addr, pc);
    chk({tag, ".v"}, {15'd0, de_v}, {15'd0, v});
    if (v) begin
      chk({tag, ".npc"}, de_npc, npc);
      chk({tag, ".ir"}, de_ir, ir);
    end
    chk({tag, ".nf"}, perf_fetched, nf);
    chk({tag, ".nb"}, perf_bubbles, nb);
  endtask

  initial begin
    rst_n = 1'b0;
    icache_r = 1'b0;
    v_de_br_stall = 1'b0;
    v_agex_br_stall = 1'b0;
    v_mem_br_stall = 1'b0;
    dep_stall = 1'b0;
    mem_stall = 1'b0;
    mem_pcmux = 2'd0;
    target_pc = 16'h0000;
    trap_pc = 16'h0000;

    // Reset state
    step(); step();
    chk("rst.addr", icache_addr, 16'h3000);
    chk("rst.rd", {15'd0, icache_rd}, 16'd1);
    chk("rst.v", {15'd0, de_v}, 16'd0);
    chk("rst.ir", de_ir, 16'h0000);
    chk("rst.npc", de_npc, 16'h0000);
    chk("rst.nf", perf_fetched, 16'd0);
    chk("rst.nb", perf_bubbles, 16'd0);

    // Straight-line fetch from 3000
    rst_n = 1'b1;
    icache_r = 1'b1;
    step(); chk_all("f3000", 16'h3002, 1'b1, 16'h3002, 16'h3000 ^ K, 16'd1, 16'd0);
    step(); chk_all("f3002", 16'h3004, 1'b1, 16'h3004, 16'h3002 ^ K, 16'd2, 16'd0);
    step(); chk_all("f3004", 16'h3006, 1'b1, 16'h3006, 16'h3004 ^ K, 16'd3, 16'd0);
    repeat (5) step();
    chk_all("f300e", 16'h3010, 1'b1, 16'h3010, 16'h300E ^ K, 16'd8, 16'd0);

    // Icache miss for four cycles at 3010
    icache_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("miss.pc", icache_addr, 16'h3010);
      chk("miss.v", {15'd0, de_v}, 16'd0);
    end
    chk("miss.nb", perf_bubbles, 16'd4);
    icache_r = 1'b1;
    step(); chk_all("f3010", 16'h3012, 1'b1, 16'h3012, 16'h3010 ^ K, 16'd9, 16'd4);

    // Dependency stall freezes DE, PC and counters
    dep_stall = 1'b1;
    step(); chk_all("dep1", 16'h3012, 1'b1, 16'h3012, 16'h3010 ^ K, 16'd9, 16'd4);
    step(); chk_all("dep2", 16'h3012, 1'b1, 16'h3012, 16'h3010 ^ K, 16'd9, 16'd4);
    dep_stall = 1'b0;

    // Taken branch: instruction at 3012 is the branch
    step(); chk_all("f3012", 16'h3014, 1'b1, 16'h3014, 16'h3012 ^ K, 16'd10, 16'd4);
    v_de_br_stall = 1'b1;
    step(); chk_all("br.de", 16'h3014, 1'b0, 16'h0, 16'h0, 16'd10, 16'd5);
    chk("br.rd0", {15'd0, icache_rd}, 16'd0);
    v_de_br_stall = 1'b0; v_agex_br_stall = 1'b1;
    step(); chk_all("br.agex", 16'h3014, 1'b0, 16'h0, 16'h0, 16'd10, 16'd6);
    v_agex_br_stall = 1'b0; v_mem_br_stall = 1'b1;
    mem_pcmux = 2'd1; target_pc = 16'h4001;
    step(); chk_all("br.mem", 16'h4000, 1'b0, 16'h0, 16'h0, 16'd10, 16'd7);
    chk("br.rd1", {15'd0, icache_rd}, 16'd1);
    v_mem_br_stall = 1'b0; mem_pcmux = 2'd0;
    step(); chk_all("f4000", 16'h4002, 1'b1, 16'h4002, 16'h4000 ^ K, 16'd11, 16'd7);

    // Not-taken branch keeps PC
    v_de_br_stall = 1'b1;
    step(); chk_all("nt.de", 16'h4002, 1'b0, 16'h0, 16'h0, 16'd11, 16'd8);
    v_de_br_stall = 1'b0; v_mem_br_stall = 1'b1; mem_pcmux = 2'd0;
    step(); chk_all("nt.mem", 16'h4002, 1'b0, 16'h0, 16'h0, 16'd11, 16'd9);
    chk("nt.rd", {15'd0, icache_rd}, 16'd1);
    v_mem_br_stall = 1'b0;

    // Trap redirect deferred by mem_stall
    v_de_br_stall = 1'b1;
    step(); chk_all("tr.de", 16'h4002, 1'b0, 16'h0, 16'h0, 16'd11, 16'd10);
    v_de_br_stall = 1'b0; v_mem_br_stall = 1'b1;
    mem_pcmux = 2'd2; trap_pc = 16'h0200; mem_stall = 1'b1;
    step(); chk_all("tr.ms1", 16'h4002, 1'b0, 16'h0, 16'h0, 16'd11, 16'd10);
    chk("tr.rd", {15'd0, icache_rd}, 16'd0);
    step(); chk_all("tr.ms2", 16'h4002, 1'b0, 16'h0, 16'h0, 16'd11, 16'd10);
    mem_stall = 1'b0;
    step(); chk_all("tr.res", 16'h0200, 1'b0, 16'h0, 16'h0, 16'd11, 16'd11);
    v_mem_br_stall = 1'b0; mem_pcmux = 2'd0;
    step(); chk_all("f0200", 16'h0202, 1'b1, 16'h0202, 16'h0200 ^ K, 16'd12, 16'd11);

    // Redirect to odd FFFF aligns to FFFE, then PC wraps to 0000
    v_mem_br_stall = 1'b1; mem_pcmux = 2'd1; target_pc = 16'hFFFF;
    step(); chk_all("wr.res", 16'hFFFE, 1'b0, 16'h0, 16'h0, 16'd12, 16'd12);
    v_mem_br_stall = 1'b0; mem_pcmux = 2'd0;
    step(); chk_all("fFFFE", 16'h0000, 1'b1, 16'h0000, 16'hFFFE ^ K, 16'd13, 16'd12);

    // Asynchronous reset in the middle of BR_WAIT
    v_de_br_stall = 1'b1;
    step(); chk("bw.rd", {15'd0, icache_rd}, 16'd0);
    rst_n = 1'b0;
    #2;
    chk("ar.pc", icache_addr, 16'h3000);
    chk("ar.v", {15'd0, de_v}, 16'd0);
    chk("ar.rd", {15'd0, icache_rd}, 16'd1);
    chk("ar.nf", perf_fetched, 16'd0);
    chk("ar.nb", perf_bubbles, 16'd0);
    v_de_br_stall = 1'b0;
    icache_r = 1'b0;
    step();
    rst_n = 1'b1;

    // Bubble counter saturation: 65535 bubbles reach FFFF, one more stays
    repeat (65535) step();
    chk("sat.nb", perf_bubbles, 16'hFFFF);
    chk("sat.nf", perf_fetched, 16'd0);
    step();
    chk("sat.hold", perf_bubbles, 16'hFFFF);
    chk("sat.pc", icache_addr, 16'h3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
